// File: rtl/div_share_arb.sv
// div_share_arb: round-robin sharing of one iterative divider (start/done) among NREQ requesters.
// One division is outstanding at a time. Results are returned tagged with the requester index.
// Optional macro DIVARB_DIV0_TRAP_EN: a zero divisor is answered locally without starting the divider.
module div_share_arb #(
    parameter int unsigned BITS = 16,
    parameter int unsigned NREQ = 4,
    localparam int unsigned IDW = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*BITS-1:0] req_dividend,
    input  logic [NREQ*BITS-1:0] req_divisor,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [BITS-1:0]      rsp_quotient,
    output logic [BITS-1:0]      rsp_remainder,
    output logic                 rsp_div0,
    output logic                 div_start,
    output logic [BITS-1:0]      div_dividend,
    output logic [BITS-1:0]      div_divisor,
    input  logic                 div_done,
    input  logic [BITS-1:0]      div_quotient,
    input  logic [BITS-1:0]      div_remainder
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  pos;
    logic [IDW-1:0]  grant_id;
    logic [NREQ-1:0] grant;
    logic            grant_any;
    logic            accept;
    logic            zero_div;
    logic [BITS-1:0] sel_dividend;
    logic [BITS-1:0] sel_divisor;

    // Round-robin search: first valid requester at or above the pointer, with wrap.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        pos       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pos = IDW'((32'(ptr) + k) % NREQ);
            if (!grant_any && req_valid[pos]) begin
                grant_any   = 1'b1;
                grant[pos]  = 1'b1;
                grant_id    = pos;
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                sel_dividend = req_dividend[i*BITS +: BITS];
                sel_divisor  = req_divisor[i*BITS +: BITS];
            end
        end
    end

    assign accept = |req_ready;

`ifdef DIVARB_DIV0_TRAP_EN
    assign zero_div = (sel_divisor == '0);
`else
    assign zero_div = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = zero_div ? S_RESP : S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (div_done) state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Grant is only offered while idle.
    always_comb begin
        req_ready = '0;
        if (state == S_IDLE) begin
            req_ready = grant;
        end
    end

    // Operand capture, divider start pulse, response registers and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr           <= '0;
            div_start     <= 1'b0;
            div_dividend  <= '0;
            div_divisor   <= '0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
`ifdef DIVARB_DIV0_TRAP_EN
            rsp_div0      <= 1'b0;
`endif
        end else begin
            div_start <= accept && !zero_div;
            if (accept) begin
                div_dividend <= sel_dividend;
                div_divisor  <= sel_divisor;
                rsp_id       <= grant_id;
                if (32'(grant_id) == NREQ - 1) begin
                    ptr <= '0;
                end else begin
                    ptr <= grant_id + IDW'(1);
                end
`ifdef DIVARB_DIV0_TRAP_EN
                if (zero_div) begin
                    rsp_valid     <= 1'b1;
                    rsp_quotient  <= '1;
                    rsp_remainder <= sel_dividend;
                    rsp_div0      <= 1'b1;
                end
`endif
            end
            if (state == S_WAIT && div_done) begin
                rsp_valid     <= 1'b1;
                rsp_quotient  <= div_quotient;
                rsp_remainder <= div_remainder;
`ifdef DIVARB_DIV0_TRAP_EN
                rsp_div0      <= 1'b0;
`endif
            end
            if (state == S_RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifndef DIVARB_DIV0_TRAP_EN
    assign rsp_div0 = 1'b0;
`endif

endmodule

// File: tb/tb_div_share_arb.sv
// Bench for div_share_arb: directed vector table, hand-written multi-cycle sequences,
// and a randomized run checked against a transaction-level reference model.
module tb_div_share_arb;

    localparam int unsigned BITS = 16;
    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;
`ifdef DIVARB_DIV0_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*BITS-1:0] req_dividend;
    logic [NREQ*BITS-1:0] req_divisor;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [BITS-1:0]      rsp_quotient;
    logic [BITS-1:0]      rsp_remainder;
    logic                 rsp_div0;
    logic                 div_start;
    logic [BITS-1:0]      div_dividend;
    logic [BITS-1:0]      div_divisor;
    logic                 div_done;
    logic [BITS-1:0]      div_quotient;
    logic [BITS-1:0]      div_remainder;

    logic [BITS-1:0] op_a [NREQ];
    logic [BITS-1:0] op_b [NREQ];

    int n_checks  = 0;
    int n_pass    = 0;
    int start_cnt = 0;
    int div_lat   = 3;

    div_share_arb #(.BITS(BITS), .NREQ(NREQ)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_div0(rsp_div0),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_dividend[i*BITS +: BITS] = op_a[i];
            req_divisor[i*BITS +: BITS]  = op_b[i];
        end
    end

    // Behavioural divider: fixed latency chosen at start, keeps running through DUT reset.
    initial begin
        logic [BITS-1:0] ma, mb;
        int cnt;
        bit busy;
        busy = 1'b0; cnt = 0; ma = '0; mb = '0;
        div_done = 1'b0; div_quotient = '0; div_remainder = '0;
        forever begin
            @(posedge clk); #1;
            div_done = 1'b0;
            if (busy) begin
                if (cnt == 0) begin
                    div_done      = 1'b1;
                    div_quotient  = ref_q(ma, mb);
                    div_remainder = ref_r(ma, mb);
                    busy = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (div_start) begin
                busy = 1'b1; cnt = div_lat; ma = div_dividend; mb = div_divisor;
                start_cnt++;
            end
        end
    end

    function automatic logic [BITS-1:0] ref_q(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        return (b == '0) ? '1 : a / b;
    endfunction

    function automatic logic [BITS-1:0] ref_r(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        return (b == '0) ? a : a % b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    // Wait (bounded) for any grant; ends at the negedge where it is visible.
    task automatic wait_grant(input int id, input string tag);
        bit got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            at_neg();
            if (req_ready != '0) got = 1'b1; else tick();
        end
        check({tag, " grant"}, 32'(req_ready), 32'(1) << id);
    endtask

    task automatic wait_rsp(input string tag);
        bit got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            at_neg();
            if (rsp_valid) got = 1'b1; else tick();
        end
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    endtask

    task automatic finish_rsp(input int id, input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                              input logic [BITS-1:0] q, input logic [BITS-1:0] r,
                              input int s0, input string tag);
        bit d0;
        d0 = TRAP && (b == '0);
        wait_rsp(tag);
        check({tag, " id"}, 32'(rsp_id), 32'(id));
        check({tag, " quot"}, 32'(rsp_quotient), 32'(q));
        check({tag, " rem"}, 32'(rsp_remainder), 32'(r));
        check({tag, " div0"}, 32'(rsp_div0), 32'(d0));
        check({tag, " starts"}, 32'(start_cnt - s0), d0 ? 32'd0 : 32'd1);
        check({tag, " opnd"}, {div_dividend, div_divisor}, {a, b});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, " rsp_drop"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic serve(input int id, input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                         input logic [BITS-1:0] q, input logic [BITS-1:0] r,
                         input bit keep, input string tag);
        int s0;
        s0 = start_cnt;
        wait_grant(id, tag);
        tick();
        if (!keep) req_valid[id] = 1'b0;
        finish_rsp(id, a, b, q, r, s0, tag);
    endtask

    task automatic run_one(input int id, input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                           input logic [BITS-1:0] q, input logic [BITS-1:0] r, input string tag);
        op_a[id] = a; op_b[id] = b; req_valid[id] = 1'b1;
        serve(id, a, b, q, r, 1'b0, tag);
    endtask

    typedef struct {
        int              id;
        logic [BITS-1:0] a;
        logic [BITS-1:0] b;
        logic [BITS-1:0] q;
        logic [BITS-1:0] r;
    } vec_t;

    typedef struct {
        int              id;
        logic [BITS-1:0] q;
        logic [BITS-1:0] r;
        logic            d0;
    } exp_t;

    task automatic random_run();
        bit   pend [NREQ];
        exp_t expq [$];
        exp_t e;
        int   issued = 0, done_n = 0, rr = 0, hs, w, j;
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        for (int cyc = 0; cyc < 20000 && done_n < 100; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && issued < 100 && $urandom_range(0, 3) == 0) begin
                    int sel = int'($urandom_range(0, 7));
                    op_a[i] = 16'($urandom);
                    op_b[i] = (sel == 0) ? 16'd0 : (sel == 1) ? 16'($urandom) : 16'($urandom_range(1, 255));
                    pend[i] = 1'b1; req_valid[i] = 1'b1; issued++;
                end
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            div_lat   = int'($urandom_range(0, 6));
            at_neg();
            hs = -1;
            if (req_ready != '0) begin
                w = -1;
                for (int k = 0; k < NREQ; k++) begin
                    j = (rr + k) % NREQ;
                    if (w < 0 && pend[j]) w = j;
                end
                check("rand grant", 32'(req_ready), (w < 0) ? 32'd0 : (32'(1) << w));
                if (w >= 0) begin
                    e.id = w; e.q = ref_q(op_a[w], op_b[w]); e.r = ref_r(op_a[w], op_b[w]);
                    e.d0 = TRAP && (op_b[w] == '0);
                    expq.push_back(e);
                    rr = (w + 1) % NREQ; hs = w;
                end
            end
            if (rsp_valid && rsp_ready) begin
                check("rand outstanding", 32'(expq.size()), 32'd1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    check("rand id", 32'(rsp_id), 32'(e.id));
                    check("rand quot", 32'(rsp_quotient), 32'(e.q));
                    check("rand rem", 32'(rsp_remainder), 32'(e.r));
                    check("rand div0", 32'(rsp_div0), 32'(e.d0));
                end
                done_n++;
            end
            tick();
            if (hs >= 0) begin
                pend[hs] = 1'b0; req_valid[hs] = 1'b0;
            end
        end
        rsp_ready = 1'b0;
        check("rand completed", 32'(done_n), 32'd100);
    endtask

    initial begin
        vec_t vecs [6];
        int   s0;
        bit   seen;

        vecs[0] = '{2, 16'd11,    16'd3,   16'd3,      16'd2};
        vecs[1] = '{0, 16'd100,   16'd7,   16'd14,     16'd2};
        vecs[2] = '{1, 16'd200,   16'd9,   16'd22,     16'd2};
        vecs[3] = '{2, 16'd50,    16'd5,   16'd10,     16'd0};
        vecs[4] = '{3, 16'd65535, 16'd256, 16'd255,    16'd255};
        vecs[5] = '{3, 16'd1234,  16'd0,   16'hFFFF,   16'd1234};

        reset = 1'b1; rsp_ready = 1'b0; req_valid = '0;
        for (int i = 0; i < NREQ; i++) begin op_a[i] = '0; op_b[i] = '0; end

        // Reset state.
        tick(); tick();
        at_neg();
        check("rst req_ready", 32'(req_ready), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp", {rsp_quotient, rsp_remainder}, 32'd0);
        check("rst id/div0/start", {rsp_id, rsp_div0, div_start}, 32'd0);
        check("rst div opnd", {div_dividend, div_divisor}, 32'd0);
        tick();
        reset = 1'b0;

        // Directed single-request vectors.
        for (int v = 0; v < 6; v++) begin
            run_one(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].q, vecs[v].r, $sformatf("vec%0d", v));
        end

        // All four requesters at once from reset: grants 0,1,2,3.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = vecs[i+1].a; op_b[i] = vecs[i+1].b; req_valid[i] = 1'b1;
        end
        for (int i = 0; i < NREQ; i++) begin
            serve(i, vecs[i+1].a, vecs[i+1].b, vecs[i+1].q, vecs[i+1].r, 1'b0, $sformatf("all4_%0d", i));
        end

        // Requesters 0 and 1 held valid: grants alternate.
        do_reset();
        op_a[0] = 16'd40; op_b[0] = 16'd6; op_a[1] = 16'd90; op_b[1] = 16'd8;
        req_valid[0] = 1'b1; req_valid[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) serve(0, 16'd40, 16'd6, 16'd6, 16'd4, 1'b1, $sformatf("alt%0d", k));
            else            serve(1, 16'd90, 16'd8, 16'd11, 16'd2, k != 3, $sformatf("alt%0d", k));
        end
        req_valid[0] = 1'b0;

        // Backpressure: response held for 10 cycles while another request waits.
        op_a[0] = 16'd1000; op_b[0] = 16'd10; req_valid[0] = 1'b1;
        wait_grant(0, "bp r0");
        tick();
        req_valid[0] = 1'b0;
        op_a[1] = 16'd77; op_b[1] = 16'd7; req_valid[1] = 1'b1;
        wait_rsp("bp r0");
        s0 = start_cnt;
        for (int c = 0; c < 10; c++) begin
            check("bp hold valid", 32'(rsp_valid), 32'd1);
            check("bp hold data", {rsp_quotient, rsp_remainder}, {16'd100, 16'd0});
            check("bp hold id", 32'(rsp_id), 32'd0);
            check("bp no ready", 32'(req_ready), 32'd0);
            check("bp no start", 32'(div_start), 32'd0);
            tick(); at_neg();
        end
        check("bp start count", 32'(start_cnt - s0), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp rsp_drop", 32'(rsp_valid), 32'd0);
        at_neg();
        check("bp resume", 32'(req_ready), 32'd2);
        s0 = start_cnt;
        tick();
        req_valid[1] = 1'b0;
        finish_rsp(1, 16'd77, 16'd7, 16'd11, 16'd0, s0, "bp r1");

        // Reset while waiting on the divider: late div_done must be ignored.
        div_lat = 8;
        op_a[2] = 16'd500; op_b[2] = 16'd3; req_valid[2] = 1'b1;
        wait_grant(2, "rstw");
        tick();
        req_valid[2] = 1'b0;
        check("rstw start", 32'(div_start), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        at_neg();
        check("rstw rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstw rsp", {rsp_quotient, rsp_remainder}, 32'd0);
        check("rstw id/div0/start", {rsp_id, rsp_div0, div_start}, 32'd0);
        check("rstw div opnd", {div_dividend, div_divisor}, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick(); at_neg();
            if (rsp_valid) seen = 1'b1;
        end
        check("rstw late done ignored", 32'(seen), 32'd0);
        tick();
        div_lat = 3;
        run_one(2, 16'd500, 16'd3, 16'd166, 16'd2, "rstw after");

        // Randomized traffic against the reference model.
        do_reset();
        random_run();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/div_share_arb.md
Name: div_share_arb

Overview:
- Shares one iterative divider (start/done protocol) between NREQ independent requesters.
- Round-robin arbitration; one division outstanding at a time.
- Captures the winner's operands, pulses the divider start, waits for done, then returns quotient/remainder tagged with the requester ID.
- Sits between the application-side requesters and the divider instance.

Parameters:
- BITS, 16, operand/result width; must match the divider's BITS.
- NREQ, 4, number of requesters (2..16).
- IDW, $clog2(NREQ), width of the requester ID tag (derived; not overridden).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle
- req_dividend  in  NREQ*BITS  packed dividends; requester i at [i*BITS +: BITS]
- req_divisor  in  NREQ*BITS  packed divisors; same packing
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  IDW  requester index owning the response
- rsp_quotient  out  BITS  quotient
- rsp_remainder  out  BITS  remainder
- rsp_div0  out  1  divide-by-zero flag; constant 0 unless DIVARB_DIV0_TRAP_EN is defined
- div_start  out  1  one-cycle start pulse to the divider
- div_dividend  out  BITS  registered dividend to the divider
- div_divisor  out  BITS  registered divisor to the divider
- div_done  in  1  divider completion pulse
- div_quotient  in  BITS  divider quotient
- div_remainder  in  BITS  divider remainder

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_quotient=0, rsp_remainder=0, rsp_div0=0, div_start=0, div_dividend=0, div_divisor=0; FSM=IDLE; round-robin pointer=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready is combinational: one-hot grant to the first requester with req_valid set, searching from pointer upward with wrap; all zeros if no request.
  - On handshake (req_valid[i] & req_ready[i]): register the operands into div_dividend/div_divisor and i into rsp_id; pointer <= (i+1) mod NREQ; go to ISSUE.
- ISSUE: div_start=1 for exactly one cycle; go to WAIT.
- WAIT:
  - div_dividend/div_divisor held stable.
  - On div_done: capture div_quotient/div_remainder into rsp_quotient/rsp_remainder; rsp_valid<=1; go to RESP.
  - A div_done in any other state is ignored.
- RESP:
  - rsp_valid and all rsp_* outputs held stable until rsp_ready=1.
  - On that cycle, rsp_valid<=0 next cycle; go to IDLE.
  - req_ready=0 in RESP; no new accept in the same cycle as rsp_ready.
- Latency: handshake at cycle T → div_start at T+1 → response valid the cycle after div_done. Minimum request-to-request spacing is divider latency + 3 cycles.
- req_ready is 0 in every state except IDLE.
- Requesters must hold req_valid and operands stable until accepted. Dropping req_valid before acceptance is legal and simply withdraws the request.
- Fairness: a continuously requesting requester is granted within NREQ grants.
- Reset mid-operation (any state): return to the reset values next cycle. Any in-flight result is discarded and a later div_done is ignored.
- Divisor 0 (macro undefined): issued to the divider normally; divider results passed through unchanged; rsp_div0=0.

Optional Feature:
- Macro: DIVARB_DIV0_TRAP_EN.
- Defined: on accept with divisor==0, the FSM goes IDLE→RESP directly and div_start is not pulsed. Response values: rsp_quotient={BITS{1'b1}}, rsp_remainder=dividend, rsp_div0=1. rsp_valid is asserted the cycle after accept. rsp_div0=0 for all normal divisions.
- Undefined: no zero check; rsp_div0 is tied to 0.

Test Plan:
- Single request: requester 2 sends 11/3 → div_start once; rsp_id=2, quotient=3, remainder=2, rsp_valid held until rsp_ready.
- All four requesters valid simultaneously from reset, each with 100/7, 200/9, 50/5, 65535/256 → grants in order 0,1,2,3; results 14r2, 22r2, 10r0, 255r255 with the matching rsp_id.
- Requesters 0 and 1 continuously valid → grants alternate 0,1,0,1; requester 1 is never granted twice in a row while 0 is waiting.
- Backpressure: rsp_ready held 0 for 10 cycles after rsp_valid → outputs stable, req_ready all zero, no div_start; accept resumes the cycle after rsp_ready.
- Reset asserted in WAIT → all outputs return to reset values; the subsequent div_done produces no rsp_valid; a new request afterwards completes correctly.
- Macro defined: 1234/0 from requester 3 → no div_start; rsp_div0=1, quotient=16'hFFFF, remainder=1234, rsp_id=3. Random 100-request run is self-checked against / and %.
